scpad_rxbar: RTL and testbench
==============================

# scpad_rxbar

Read-side crossbar for one scratchpad instance. It takes per-column bank read data in physical column order and un-permutes it into request element order, so `out_data[i] = in_data[sel[i]]`. Request metadata (src, slot mask, valid mask) is carried alongside in a stall-aware delay line of fixed depth. The block sits between the scratchpad bank read ports and the response arbiter (the "tail" of the read path), mirroring the write crossbar on the request side.

## Interface
- `NUM_COLS`, 32: lanes (columns); power of two, at least 2.
- `ELEM_BITS`, 16: bits per element.
- `XBAR_LATENCY`, 2: pipeline depth in cycles; at least 1.
- `SRC_BITS`, 4: width of the requester-source tag.
- `SLOT_BITS`, 8: width of the slot mask.
- SEL_W, derived as $clog2(NUM_COLS); not overridable.

- `clk` in 1: clock.
- `n_rst` in 1: synchronous, active-low reset.
- `stall` in 1: downstream stall. When 1, the whole pipe holds and no input is sampled.
- `in_valid` in 1: bank read response valid.
- `in_src` in SRC_BITS: requester tag.
- `in_slot_mask` in SLOT_BITS: slot mask, passed through untouched.
- `in_valid_mask` in NUM_COLS: per-lane element-valid mask.
- `in_sel` in NUM_COLS*SEL_W: for output lane i, the source column index (lane i uses bits [i*SEL_W +: SEL_W]).
- `in_data` in NUM_COLS*ELEM_BITS: bank data in physical column order.
- `out_valid` out 1: response valid.
- `out_src` out SRC_BITS: delayed `in_src`.
- `out_slot_mask` out SLOT_BITS: delayed `in_slot_mask`.
- `out_valid_mask` out NUM_COLS: delayed `in_valid_mask`.
- `out_data` out NUM_COLS*ELEM_BITS: permuted data in element order.
- `in_flight` out $clog2(XBAR_LATENCY+1): number of valid entries currently in the pipe.
- `perf_resp_cnt` out 32: completed responses (only with SCPAD_RXBAR_PERF_EN).
- `perf_stall_cnt` out 32: stall cycles (only with SCPAD_RXBAR_PERF_EN).

## Operation
- **Stage 0 (combinational):** gather `g[i] = in_data[in_sel[i]]` for every lane.
  - Duplicate sel values are legal; they broadcast one column to several lanes.
  - Lanes with `in_valid_mask[i]=0` are forced to 0.
  - If `in_valid=0`, the whole stage-0 word (data and metadata) is forced to 0.
- **Pipe:** XBAR_LATENCY register stages. Each stage holds {valid, src, slot_mask, valid_mask, data}.
  - When `stall=0`, every stage shifts by one: stage0 loads the input, and the last stage drives the outputs.
  - When `stall=1`, all stages hold. The input is not captured, so upstream must hold its response while stall is high.
- **Outputs:** driven directly from the last-stage register; there is no combinational input-to-output path.
- **`in_flight` counter:**
  - On a shift cycle, it increments by `in_valid` and decrements by the last stage's valid.
  - A simultaneous increment and decrement leaves it unchanged.
  - It is held while stalled.
  - It never exceeds XBAR_LATENCY; no overflow handling is required.
- **Reset:** when `n_rst=0` at a clock edge, all stage registers, `in_flight` and the perf counters clear to 0.
  - Reset wins over stall.
  - A reset taken mid-stream drops every in-flight response silently.

## Timing
- **Latency:** a response sampled at edge T (with `stall=0`) appears on the outputs after XBAR_LATENCY non-stalled edges. With no stalls it is visible in the cycle after edge T+XBAR_LATENCY-1.
- **Stalls:** each stalled cycle adds exactly one cycle of latency. Outputs are stable, bit-for-bit, during a stall.
- **Throughput:** one response per non-stalled cycle. Back-to-back `in_valid` produces back-to-back `out_valid` with no bubbles.
- **Reset values:** every output is 0 (including the perf counters when they are compiled in).
- **Bubbles:** an invalid input cycle yields a zero bubble on all output fields. Data from a previous response is never leaked into a bubble.

## Configuration
- Controlled by `SCPAD_RXBAR_PERF_EN`.
- **Defined:**
  - `perf_resp_cnt` increments on every edge where `stall=0` and the last stage is valid.
  - `perf_stall_cnt` increments on every edge where `stall=1`.
  - Both wrap modulo 2^32 and clear on reset.
- **Undefined:**
  - Both ports still exist and are tied to 0.
  - No counter flops are synthesized.
  - All other behaviour is identical.

## Test plan
- **Identity:** NUM_COLS=32, `in_sel[i]=i`, `in_data[j]=j+0x100`, `in_valid_mask` all ones, `stall=0` -> after 2 cycles, `out_data[i]=i+0x100`, `out_valid=1` for exactly one cycle, src and slot_mask match the input.
- **Reverse and broadcast:** `in_sel[i]=31-i` -> `out_data[i]=0x100+31-i`. Then all `in_sel=5` -> every lane equals 0x105.
- **Masking and bubble:** `in_valid_mask=0x0000FFFF` -> lanes 16..31 read 0. Follow with an `in_valid=0` cycle -> that output cycle has every field 0.
- **Stall mid-pipe:** issue responses A and B back to back, assert `stall` for 3 cycles after B -> `in_flight` stays at 2 while outputs hold. A emerges 3 cycles late, B on the next edge, and `in_flight` returns to 0.
- **Reset mid-stream:** with 2 in flight, pull `n_rst` low for one edge (with `stall=1` also asserted) -> all outputs and `in_flight` are 0 on the next cycle, and neither A nor B ever appears.
- **Perf counters (with SCPAD_RXBAR_PERF_EN):** 10 responses with 4 stall cycles -> `perf_resp_cnt=10` and `perf_stall_cnt=4`. Without the macro, both read 0.

Source files
------------

// File: rtl/scpad_rxbar.sv
// Read-side scratchpad crossbar: gathers bank columns into element order and carries
// response metadata through a stall-aware pipe. Optional perf counters: SCPAD_RXBAR_PERF_EN.
module scpad_rxbar #(
  parameter int unsigned NUM_COLS     = 32,
  parameter int unsigned ELEM_BITS    = 16,
  parameter int unsigned XBAR_LATENCY = 2,
  parameter int unsigned SRC_BITS     = 4,
  parameter int unsigned SLOT_BITS    = 8,
  localparam int unsigned SEL_W       = $clog2(NUM_COLS),
  localparam int unsigned CNT_W       = $clog2(XBAR_LATENCY + 1)
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          stall,
  input  logic                          in_valid,
  input  logic [SRC_BITS-1:0]           in_src,
  input  logic [SLOT_BITS-1:0]          in_slot_mask,
  input  logic [NUM_COLS-1:0]           in_valid_mask,
  input  logic [NUM_COLS*SEL_W-1:0]     in_sel,
  input  logic [NUM_COLS*ELEM_BITS-1:0] in_data,
  output logic                          out_valid,
  output logic [SRC_BITS-1:0]           out_src,
  output logic [SLOT_BITS-1:0]          out_slot_mask,
  output logic [NUM_COLS-1:0]           out_valid_mask,
  output logic [NUM_COLS*ELEM_BITS-1:0] out_data,
  output logic [CNT_W-1:0]              in_flight,
  output logic [31:0]                   perf_resp_cnt,
  output logic [31:0]                   perf_stall_cnt
);

  localparam int unsigned Last = XBAR_LATENCY - 1;

  logic [NUM_COLS*ELEM_BITS-1:0] g_data;
  logic [SRC_BITS-1:0]           g_src;
  logic [SLOT_BITS-1:0]          g_slot;
  logic [NUM_COLS-1:0]           g_vmask;

  logic                          valid_q [XBAR_LATENCY];
  logic [SRC_BITS-1:0]           src_q   [XBAR_LATENCY];
  logic [SLOT_BITS-1:0]          slot_q  [XBAR_LATENCY];
  logic [NUM_COLS-1:0]           vmask_q [XBAR_LATENCY];
  logic [NUM_COLS*ELEM_BITS-1:0] data_q  [XBAR_LATENCY];

  logic [CNT_W-1:0] in_flight_q, in_flight_d;

  // Invalid responses become all-zero bubbles so stale data never reaches the outputs.
  always_comb begin
    g_data = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (in_valid && in_valid_mask[i]) begin
        g_data[i*ELEM_BITS +: ELEM_BITS] =
          in_data[int'(in_sel[i*SEL_W +: SEL_W])*ELEM_BITS +: ELEM_BITS];
      end
    end
    g_src   = in_valid ? in_src        : '0;
    g_slot  = in_valid ? in_slot_mask  : '0;
    g_vmask = in_valid ? in_valid_mask : '0;
  end

  always_comb begin
    in_flight_d = in_flight_q + CNT_W'(in_valid) - CNT_W'(valid_q[Last]);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int l = 0; l < XBAR_LATENCY; l++) begin
        valid_q[l] <= 1'b0;
        src_q[l]   <= '0;
        slot_q[l]  <= '0;
        vmask_q[l] <= '0;
        data_q[l]  <= '0;
      end
      in_flight_q <= '0;
    end else if (!stall) begin
      valid_q[0] <= in_valid;
      src_q[0]   <= g_src;
      slot_q[0]  <= g_slot;
      vmask_q[0] <= g_vmask;
      data_q[0]  <= g_data;
      for (int l = 1; l < XBAR_LATENCY; l++) begin
        valid_q[l] <= valid_q[l-1];
        src_q[l]   <= src_q[l-1];
        slot_q[l]  <= slot_q[l-1];
        vmask_q[l] <= vmask_q[l-1];
        data_q[l]  <= data_q[l-1];
      end
      in_flight_q <= in_flight_d;
    end
  end

  assign out_valid      = valid_q[Last];
  assign out_src        = src_q[Last];
  assign out_slot_mask  = slot_q[Last];
  assign out_valid_mask = vmask_q[Last];
  assign out_data       = data_q[Last];
  assign in_flight      = in_flight_q;

`ifdef SCPAD_RXBAR_PERF_EN
  logic [31:0] perf_resp_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      perf_resp_q  <= '0;
      perf_stall_q <= '0;
    end else if (stall) begin
      perf_stall_q <= perf_stall_q + 32'd1;
    end else if (valid_q[Last]) begin
      perf_resp_q <= perf_resp_q + 32'd1;
    end
  end

  assign perf_resp_cnt  = perf_resp_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_resp_cnt  = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_scpad_rxbar.sv
// Self-checking bench for scpad_rxbar: directed steps plus randomized traffic against
// a response-history model (output = response accepted XBAR_LATENCY shifts ago).
module tb_scpad_rxbar;

  localparam int unsigned NC = 32;
  localparam int unsigned EB = 16;
  localparam int unsigned L  = 2;
  localparam int unsigned SW = 5;

  typedef struct packed {
    logic            v;
    logic [3:0]      src;
    logic [7:0]      slot;
    logic [NC-1:0]   vm;
    logic [NC*EB-1:0] d;
  } resp_t;

  logic clk = 1'b0;
  logic n_rst, stall, in_valid;
  logic [3:0]       in_src;
  logic [7:0]       in_slot_mask;
  logic [NC-1:0]    in_valid_mask;
  logic [NC*SW-1:0] in_sel;
  logic [NC*EB-1:0] in_data;
  logic             out_valid;
  logic [3:0]       out_src;
  logic [7:0]       out_slot_mask;
  logic [NC-1:0]    out_valid_mask;
  logic [NC*EB-1:0] out_data;
  logic [1:0]       in_flight;
  logic [31:0]      perf_resp_cnt, perf_stall_cnt;

  scpad_rxbar dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .stall          (stall),
    .in_valid       (in_valid),
    .in_src         (in_src),
    .in_slot_mask   (in_slot_mask),
    .in_valid_mask  (in_valid_mask),
    .in_sel         (in_sel),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_src        (out_src),
    .out_slot_mask  (out_slot_mask),
    .out_valid_mask (out_valid_mask),
    .out_data       (out_data),
    .in_flight      (in_flight),
    .perf_resp_cnt  (perf_resp_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  resp_t       hist[$];
  int unsigned m_resp, m_stall;
  int          vecs = 0;
  int          errs = 0;

  task automatic chk(input string tag, input logic [NC*EB-1:0] obs, input logic [NC*EB-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic resp_t gather();
    resp_t r;
    r = '0;
    if (in_valid) begin
      r.v    = 1'b1;
      r.src  = in_src;
      r.slot = in_slot_mask;
      r.vm   = in_valid_mask;
      for (int i = 0; i < NC; i++) begin
        int unsigned s;
        s = in_sel[i*SW +: SW];
        if (in_valid_mask[i]) r.d[i*EB +: EB] = in_data[s*EB +: EB];
      end
    end
    return r;
  endfunction

  task automatic check_all();
    resp_t e;
    int unsigned f;
    e = (hist.size() == L) ? hist[0] : '0;
    f = 0;
    foreach (hist[k]) if (hist[k].v) f++;
    chk("out_valid", {511'b0, out_valid}, {511'b0, e.v});
    chk("out_src", {508'b0, out_src}, {508'b0, e.src});
    chk("out_slot_mask", {504'b0, out_slot_mask}, {504'b0, e.slot});
    chk("out_valid_mask", {480'b0, out_valid_mask}, {480'b0, e.vm});
    chk("out_data", out_data, e.d);
    chk("in_flight", {510'b0, in_flight}, (NC*EB)'(f));
`ifdef SCPAD_RXBAR_PERF_EN
    chk("perf_resp_cnt", {480'b0, perf_resp_cnt}, (NC*EB)'(m_resp));
    chk("perf_stall_cnt", {480'b0, perf_stall_cnt}, (NC*EB)'(m_stall));
`else
    chk("perf_resp_cnt", {480'b0, perf_resp_cnt}, '0);
    chk("perf_stall_cnt", {480'b0, perf_stall_cnt}, '0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (!n_rst) begin
      hist.delete();
      m_resp  = 0;
      m_stall = 0;
    end else if (stall) begin
      m_stall++;
    end else begin
      if (hist.size() == L && hist[0].v) m_resp++;
      hist.push_back(gather());
      if (hist.size() > L) void'(hist.pop_front());
    end
    #1 check_all();
  endtask

  task automatic sel_identity();
    for (int i = 0; i < NC; i++) in_sel[i*SW +: SW] = SW'(i);
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NC*EB/32; i++) in_data[i*32 +: 32] = $urandom;
    for (int i = 0; i < NC; i++) in_sel[i*SW +: SW] = SW'($urandom_range(0, NC-1));
    in_valid_mask = $urandom;
    in_src        = 4'($urandom);
    in_slot_mask  = 8'($urandom);
  endtask

  initial begin
    n_rst = 1'b0; stall = 1'b0; in_valid = 1'b0;
    in_src = '0; in_slot_mask = '0; in_valid_mask = '0; in_sel = '0;
    for (int j = 0; j < NC; j++) in_data[j*EB +: EB] = EB'(j + 'h100);
    tick(); tick();
    n_rst = 1'b1;

    // Identity permutation
    sel_identity();
    in_valid = 1'b1; in_valid_mask = '1; in_src = 4'h3; in_slot_mask = 8'hA5;
    tick();
    in_valid = 1'b0;
    tick();
    chk("ident_lane7", {496'b0, out_data[7*EB +: EB]}, 512'h107);
    chk("ident_lane31", {496'b0, out_data[31*EB +: EB]}, 512'h11f);
    tick();

    // Reverse, then broadcast column 5
    for (int i = 0; i < NC; i++) in_sel[i*SW +: SW] = SW'(NC - 1 - i);
    in_valid = 1'b1; in_src = 4'h6;
    tick();
    for (int i = 0; i < NC; i++) in_sel[i*SW +: SW] = SW'(5);
    tick();
    chk("rev_lane0", {496'b0, out_data[0 +: EB]}, 512'h11f);
    in_valid = 1'b0;
    tick();
    chk("bcast_lane20", {496'b0, out_data[20*EB +: EB]}, 512'h105);

    // Masking followed by a bubble carrying different data
    sel_identity();
    in_valid = 1'b1; in_valid_mask = 32'h0000FFFF;
    tick();
    in_valid = 1'b0; in_data = '1; in_valid_mask = '1;
    tick();
    chk("mask_lane20", {496'b0, out_data[20*EB +: EB]}, '0);
    tick();
    chk("bubble_data", out_data, '0);

    // Stall with two responses in flight
    rand_inputs(); in_valid = 1'b1; in_src = 4'h1;
    tick();
    rand_inputs(); in_src = 4'h2;
    tick();
    in_valid = 1'b0; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_in_flight", {510'b0, in_flight}, 512'd2);
    end
    stall = 1'b0;
    tick(); tick(); tick();
    chk("drain_in_flight", {510'b0, in_flight}, '0);

    // Reset with stall asserted, two responses in flight
    rand_inputs(); in_valid = 1'b1;
    tick(); tick();
    n_rst = 1'b0; stall = 1'b1;
    tick();
    chk("rst_in_flight", {510'b0, in_flight}, '0);
    n_rst = 1'b1; stall = 1'b0; in_valid = 1'b0;
    tick(); tick();
    chk("rst_no_resp", {511'b0, out_valid}, '0);

    // Perf: 10 responses, 4 stall cycles
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    for (int k = 0; k < 14; k++) begin
      stall = (k % 3 == 1) && (k < 12);
      rand_inputs(); in_valid = 1'b1;
      tick();
    end
    stall = 1'b0; in_valid = 1'b0;
    tick(); tick(); tick();
`ifdef SCPAD_RXBAR_PERF_EN
    chk("perf_resp_10", {480'b0, perf_resp_cnt}, 512'd10);
    chk("perf_stall_4", {480'b0, perf_stall_cnt}, 512'd4);
`else
    chk("perf_resp_off", {480'b0, perf_resp_cnt}, '0);
    chk("perf_stall_off", {480'b0, perf_stall_cnt}, '0);
`endif

    // Randomized traffic with occasional stalls and resets
    for (int k = 0; k < 400; k++) begin
      rand_inputs();
      in_valid = 1'($urandom);
      stall    = ($urandom_range(0, 3) == 0);
      n_rst    = ($urandom_range(0, 49) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
